if_id_skid_stage: RTL and testbench

Parametrised successor to the plain IF/ID pipeline register. Carries instruction + PC from fetch to decode with a valid/ready handshake and a 2-entry skid buffer, so decode back-pressure never creates a combinational ready path into fetch. Supports a synchronous flush for branch/jump redirect. Presents a NOP with out_valid=0 when empty.

---
 rtl/if_id_skid_stage.sv | 168 ++++++++++++++++
 tb/tb_if_id_skid_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_id_skid_stage
// Description : IF/ID pipeline stage with valid/ready handshake and a
//               2-entry skid buffer (main + skid). in_ready and all outputs
//               come straight from flops, so decode back-pressure never
//               reaches fetch combinationally. Synchronous flush empties the
//               stage; an empty stage presents NOP_INSTR with out_valid=0.
//               Optional macro IF_ID_STAGE_PERF_EN adds saturating stall and
//               flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_skid_stage #(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013),
  parameter logic [PC_W-1:0]    RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc
`ifdef IF_ID_STAGE_PERF_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    main_pc_q, main_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;

  logic w_push;
  logic w_pop;

  assign w_push = in_valid && in_ready_q;
  assign w_pop  = out_valid_q && out_ready;

  // Next-state and datapath selection; flush overrides every transition.
  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (flush) begin
      state_d      = EMPTY;
      main_instr_d = NOP_INSTR;
    end else begin
      case (state_q)
        EMPTY: begin
          if (w_push) begin
            state_d      = ONE;
            main_instr_d = in_instr;
            main_pc_d    = in_pc;
          end
        end
        ONE: begin
          if (w_push && !w_pop) begin
            state_d      = TWO;
            skid_instr_d = in_instr;
            skid_pc_d    = in_pc;
          end else if (w_push && w_pop) begin
            main_instr_d = in_instr;
            main_pc_d    = in_pc;
          end else if (w_pop) begin
            state_d      = EMPTY;
            main_instr_d = NOP_INSTR;
          end
        end
        TWO: begin
          // in_ready is low here, so only a pop can move the stage.
          if (w_pop) begin
            state_d      = ONE;
            main_instr_d = skid_instr_q;
            main_pc_d    = skid_pc_q;
          end
        end
        default: begin
          state_d      = EMPTY;
          main_instr_d = NOP_INSTR;
        end
      endcase
    end

    // Handshake outputs are registered versions of the next-state decode.
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  // State, handshake and storage registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= EMPTY;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      main_instr_q <= NOP_INSTR;
      main_pc_q    <= RESET_PC;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_instr = main_instr_q;
  assign out_pc    = main_pc_q;

`ifdef IF_ID_STAGE_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters; flush does not clear them.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (flush && ((state_q != EMPTY) || in_valid) && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_skid_stage
// Description : Self-checking bench for if_id_skid_stage. A queue model of the
//               stage is compared against the DUT on every falling edge, and
//               directed steps add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_skid_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef IF_ID_STAGE_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  if_id_skid_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc)
`ifdef IF_ID_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: FIFO of held entries ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_last_pc = 32'h0;
  logic [15:0] m_stall   = 16'h0;
  logic [15:0] m_flush   = 16'h0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_last_pc = 32'h0;
      m_stall   = 16'h0;
      m_flush   = 16'h0;
    end else begin
      bit   push, pop;
      ent_t e;
      push = in_valid && (mq.size() < 2);
      pop  = (mq.size() > 0) && out_ready;
      if ((mq.size() > 0) && !out_ready && (m_stall != 16'hFFFF)) m_stall++;
      if (flush && ((mq.size() > 0) || in_valid) && (m_flush != 16'hFFFF)) m_flush++;
      if (flush) begin
        mq.delete();
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) begin
          e.instr = in_instr;
          e.pc    = in_pc;
          mq.push_back(e);
        end
      end
      if (mq.size() > 0) m_last_pc = mq[0].pc;
    end
  end

  // Compare process: model vs DUT, away from the active edge.
  always @(negedge clk) begin
    check("cmp_out_valid", {63'b0, out_valid}, {63'b0, mq.size() != 0});
    check("cmp_in_ready",  {63'b0, in_ready},  {63'b0, mq.size() < 2});
    check("cmp_out_instr", {32'b0, out_instr}, {32'b0, (mq.size() != 0) ? mq[0].instr : NOP});
    check("cmp_out_pc",    {32'b0, out_pc},    {32'b0, (mq.size() != 0) ? mq[0].pc : m_last_pc});
`ifdef IF_ID_STAGE_PERF_EN
    check("cmp_stall_cnt", {48'b0, stall_cnt}, {48'b0, m_stall});
    check("cmp_flush_cnt", {48'b0, flush_cnt}, {48'b0, m_flush});
`endif
  end

  // Drive one cycle of inputs (called at posedge+1), return at next posedge+1.
  task automatic cyc(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                     input logic ordy, input logic fl);
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic v, input logic r,
                     input logic [31:0] ins, input logic [31:0] pc);
    check({name, "_valid"}, {63'b0, out_valid}, {63'b0, v});
    check({name, "_ready"}, {63'b0, in_ready},  {63'b0, r});
    check({name, "_instr"}, {32'b0, out_instr}, {32'b0, ins});
    check({name, "_pc"},    {32'b0, out_pc},    {32'b0, pc});
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    cyc(0, 0, 0, 0, 0);
    lit("reset_idle", 1'b0, 1'b1, NOP, 32'h0);

    // Streaming with decode always ready
    cyc(1, 32'hA, 32'h0, 1, 0);  lit("stream0", 1'b1, 1'b1, 32'hA, 32'h0);
    cyc(1, 32'hB, 32'h4, 1, 0);  lit("stream1", 1'b1, 1'b1, 32'hB, 32'h4);
    cyc(1, 32'hC, 32'h8, 1, 0);  lit("stream2", 1'b1, 1'b1, 32'hC, 32'h8);
    cyc(0, 32'h0, 32'h0, 1, 0);  lit("stream_drain", 1'b0, 1'b1, NOP, 32'h8);

    // Back-pressure fills the skid entry
    cyc(1, 32'h1100, 32'h100, 0, 0); lit("bp_one", 1'b1, 1'b1, 32'h1100, 32'h100);
    cyc(1, 32'h1104, 32'h104, 0, 0); lit("bp_two", 1'b1, 1'b0, 32'h1100, 32'h100);
    cyc(1, 32'h1108, 32'h108, 0, 0); lit("bp_hold", 1'b1, 1'b0, 32'h1100, 32'h100);
    cyc(0, 32'h0, 32'h0, 1, 0);      lit("bp_pop1", 1'b1, 1'b1, 32'h1104, 32'h104);
    cyc(0, 32'h0, 32'h0, 1, 0);      lit("bp_pop2", 1'b0, 1'b1, NOP, 32'h104);

    // Flush while full, with a competing input
    cyc(1, 32'h1300, 32'h300, 0, 0);
    cyc(1, 32'h1304, 32'h304, 0, 0);
    cyc(1, 32'h1200, 32'h200, 0, 1); lit("flush_two", 1'b0, 1'b1, NOP, 32'h300);
    cyc(0, 32'h0, 32'h0, 1, 0);      lit("flush_after", 1'b0, 1'b1, NOP, 32'h300);

    // Flush with a simultaneous pop in state ONE
    cyc(1, 32'h1310, 32'h310, 0, 0);
    cyc(0, 32'h0, 32'h0, 1, 1);      lit("flush_pop", 1'b0, 1'b1, NOP, 32'h310);

    // Asynchronous reset between clock edges
    cyc(1, 32'h1400, 32'h400, 0, 0);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1 lit("async_rst", 1'b0, 1'b1, NOP, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    cyc(1, 32'h1500, 32'h500, 1, 0); lit("post_rst", 1'b1, 1'b1, 32'h1500, 32'h500);
    cyc(0, 32'h0, 32'h0, 1, 0);

`ifdef IF_ID_STAGE_PERF_EN
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk); #1;
    cyc(1, 32'h1600, 32'h600, 0, 0);
    repeat (5) cyc(0, 32'h0, 32'h0, 0, 0);
    cyc(0, 32'h0, 32'h0, 1, 1);
    cyc(1, 32'h1700, 32'h700, 1, 1);
    check("perf_stall5", {48'b0, stall_cnt}, 64'd5);
    check("perf_flush2", {48'b0, flush_cnt}, 64'd2);
    cyc(1, 32'h1800, 32'h800, 0, 0);
    repeat (70000) cyc(0, 32'h0, 32'h0, 0, 0);
    check("perf_stall_sat", {48'b0, stall_cnt}, 64'hFFFF);
    cyc(0, 32'h0, 32'h0, 1, 0);
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
